// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the multiplier job sequencer and its watchdog:
//   W                       operand / product width
//   DEFAULT_TIMEOUT_CYCLES  RUN-state cycle budget before a job is aborted
//   wd_width()              counter width needed for a given timeout
//   WD_W                    watchdog width for the default timeout
//   seq_state_e             sequencer FSM state encoding
package mult_pkg;

  localparam int W = 16;

  // Must exceed the 65535 worst-case iterations plus controller overhead.
  localparam int DEFAULT_TIMEOUT_CYCLES = 70000;

  function automatic int wd_width(input int timeout_cycles);
    return (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles);
  endfunction

  localparam int WD_W = wd_width(DEFAULT_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    RUN,
    DRAIN,
    OUT
  } seq_state_e;

endpackage

// File: rtl/mult_job_sequencer_watchdog.sv
// mult_watchdog
// Clear/enable up-counter that raises a one-cycle expire pulse in the cycle
// the count reaches TIMEOUT_CYCLES-1 while enabled.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       forces the count back to 0 on the next edge (wins over enable)
//   enable      count advances by one per cycle while high
//   expire      count == TIMEOUT_CYCLES-1 with enable high and clear low
module mult_watchdog
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = wd_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign expire = enable && !clear && (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer
// Feeds operand pairs into the repeated-addition multiplier's serial
// START/DATA_IN load protocol and holds the product in a one-entry
// valid/ready result register. Zero operands bypass the multiplier, and a
// watchdog aborts a job that sits in RUN for TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake, in_a/in_b operands
//   out_valid/out_ready    result handshake, out_prod product, out_err abort
//   mul_start, mul_data    multiplier START and DATA_IN
//   mul_lda, mul_ldb       controller load strobes
//   mul_done, mul_prod     controller DONE level and product register
module mult_job_sequencer
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_err,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_lda,
  input  logic         mul_ldb,
  input  logic         mul_done,
  input  logic [W-1:0] mul_prod
);

  seq_state_e   state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] prod_q, prod_d;
  logic         err_q, err_d;
  logic         wd_clear;
  logic         wd_enable;
  logic         wd_expire;

  mult_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_start = 1'b0;
    mul_data  = '0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          // B=0 would wrap the multiplier's down-counter, so any zero
          // operand is answered here without starting the multiplier.
          if ((in_a == '0) || (in_b == '0)) begin
            prod_d  = '0;
            err_d   = 1'b0;
            state_d = OUT;
          end else begin
            state_d = LOAD_A;
          end
        end
      end

      LOAD_A: begin
        mul_start = 1'b1;
        mul_data  = a_q;
        if (mul_lda) begin
          state_d = LOAD_B;
        end
      end

      LOAD_B: begin
        mul_start = 1'b1;
        mul_data  = b_q;
        // A simultaneous LDA is a protocol error; only LDA counts that
        // cycle, so LDB is ignored when both strobe together.
        if (mul_ldb && !mul_lda) begin
          wd_clear = 1'b1;
          state_d  = RUN;
        end
      end

      RUN: begin
        mul_start = 1'b1;
        mul_data  = b_q;
        wd_enable = 1'b1;
        if (mul_done) begin
          prod_d  = mul_prod;
          err_d   = 1'b0;
          state_d = DRAIN;
        end else if (wd_expire) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end

      // START is released here; wait for the controller to drop DONE so it
      // is back in idle before the next job can start it again.
      DRAIN: begin
        if (!mul_done) begin
          state_d = OUT;
        end
      end

      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_prod = prod_q;
  assign out_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// tb_mult_job_sequencer
// Directed and randomized jobs for mult_job_sequencer against a behavioural
// multiplier stub and a reference product model. Built with a short watchdog
// timeout so the abort path can be exercised quickly.
module tb_mult_job_sequencer;
  import mult_pkg::*;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_prod;
  logic         out_err;
  logic         mul_start;
  logic [W-1:0] mul_data;
  logic         mul_lda = 1'b0;
  logic         mul_ldb = 1'b0;
  logic         mul_done = 1'b0;
  logic [W-1:0] mul_prod = '0;

  int vectors = 0;
  int miscompares = 0;
  int start_cycles = 0;

  always #5 clk = ~clk;

  mult_job_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_err   (out_err),
    .mul_start (mul_start),
    .mul_data  (mul_data),
    .mul_lda   (mul_lda),
    .mul_ldb   (mul_ldb),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod)
  );

  always @(posedge clk) begin
    if (mul_start) start_cycles <= start_cycles + 1;
  end

  // Behavioural multiplier controller: strobes LDA then LDB with random
  // gaps, capturing DATA_IN on each, raises DONE after a random latency and
  // holds it until START falls. With hang set it never raises DONE.
  int           phase = 0;
  int           gap = 0;
  bit           hang = 1'b0;
  logic [W-1:0] cap_a = '0;
  logic [W-1:0] cap_b = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      gap = 0;
      mul_lda = 1'b0;
      mul_ldb = 1'b0;
      mul_done = 1'b0;
      mul_prod = '0;
    end else begin
      case (phase)
        0: if (mul_start) begin
          if (gap == 0) begin
            mul_lda = 1'b1;
            cap_a = mul_data;
            gap = $urandom_range(0, 2);
            phase = 1;
          end else gap--;
        end
        1: begin
          mul_lda = 1'b0;
          if (!mul_start) phase = 0;
          else if (gap == 0) begin
            mul_ldb = 1'b1;
            cap_b = mul_data;
            gap = $urandom_range(0, 8);
            phase = 2;
          end else gap--;
        end
        2: begin
          mul_ldb = 1'b0;
          if (!mul_start) phase = 0;
          else if (!hang) begin
            if (gap == 0) begin
              mul_prod = W'(cap_a * cap_b);
              mul_done = 1'b1;
              gap = $urandom_range(0, 2);
              phase = 3;
            end else gap--;
          end
        end
        3: if (!mul_start) begin
          if (gap == 0) begin
            mul_done = 1'b0;
            gap = $urandom_range(0, 2);
            phase = 0;
          end else gap--;
        end
        default: phase = 0;
      endcase
    end
  end

  // Reference: true product reduced modulo 2^W; zero operands give zero.
  function automatic logic [W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    if (a == '0 || b == '0) return '0;
    p = longint'(a) * longint'(b);
    return W'(p % (longint'(1) << W));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and returns right after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    if (a == '0 || b == '0) checkOutput("bypass out_valid at t+1", out_valid, 1);
    else checkOutput("mul_start at t+1", mul_start, 1);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
    checkOutput("result arrives", out_valid, 1);
  endtask

  // Holds out_ready low for hold cycles (checking the result is frozen and
  // new pairs are refused), then takes the result.
  task automatic take_result(input int hold, input logic [W-1:0] exp_prod);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      step();
      checkOutput("held out_valid", out_valid, 1);
      checkOutput("held out_prod", out_prod, exp_prod);
      checkOutput("held in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("out_valid after take", out_valid, 0);
    checkOutput("in_ready after take", in_ready, 1);
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] exp_p;
    int s0;
    bit bypass;
    exp_p = ref_product(a, b);
    bypass = (a == '0 || b == '0);
    s0 = start_cycles;
    applyStimulus(a, b);
    wait_result();
    checkOutput("out_prod", out_prod, exp_p);
    checkOutput("out_err", out_err, 0);
    if (bypass) begin
      checkOutput("bypass start cycles", start_cycles - s0, 0);
    end else begin
      checkOutput("mul_data in LOAD_A", cap_a, a);
      checkOutput("mul_data in LOAD_B", cap_b, b);
    end
    take_result(hold, exp_p);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_err", out_err, 0);
    checkOutput("reset out_prod", out_prod, 0);
    checkOutput("reset mul_start", mul_start, 0);
    checkOutput("reset mul_data", mul_data, 0);
    #13;
    rst_n = 1'b1;
    step();
    checkOutput("in_ready after reset", in_ready, 1);

    // Basic product, then a single result only.
    run_job(16'd2, 16'd3, 0);
    step();
    checkOutput("no second result", out_valid, 0);

    // Zero bypass both ways.
    run_job(16'd0, 16'd5, 0);
    run_job(16'd7, 16'd0, 0);

    // Backpressure for 20 cycles.
    run_job(16'd4, 16'd5, 20);

    // Wrap modulo 2^16.
    run_job(16'd300, 16'd300, 1);
    checkOutput("wrap reference", ref_product(16'd300, 16'd300), 24464);

    // Watchdog abort with a multiplier that never finishes.
    hang = 1'b1;
    applyStimulus(16'd9, 16'd9);
    n = 0;
    while (!mul_ldb && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("stub LDB seen", mul_ldb, 1);
    step();
    n = 0;
    while (!out_err && n < 40) begin
      step();
      n++;
    end
    checkOutput("watchdog cycles after RUN entry", n, TO);
    wait_result();
    checkOutput("timeout out_err", out_err, 1);
    checkOutput("timeout out_prod", out_prod, 0);
    take_result(2, 16'd0);
    hang = 1'b0;

    // Reset in the middle of RUN.
    applyStimulus(16'd3, 16'd1000);
    n = 0;
    while (!mul_ldb && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    step();
    checkOutput("mul_start in RUN", mul_start, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async mul_start drop", mul_start, 0);
    checkOutput("async out_valid", out_valid, 0);
    checkOutput("in_ready in reset", in_ready, 1);
    #10;
    rst_n = 1'b1;
    step();
    checkOutput("no partial result", out_valid, 0);
    run_job(16'd5, 16'd6, 0);

    // Randomized jobs.
    for (int j = 0; j < 20; j++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'd0 : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'd0 : W'($urandom_range(1, 65535));
      run_job(ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
